fb_readout_dma: RTL and testbench

Reads a byte range out of the framebuffer SRAM and presents it as a byte stream. It acts as a Wishbone classic single-read master on the framebuffer slave window, the read-side counterpart of the capture DMA write path. Words are unpacked little-endian into an 8-bit valid/ready stream that feeds the SD/SPI writer. Control comes from CSR-driven start/base/len, mirroring the capture DMA's programming model.

---
 rtl/fb_readout_pkg.sv | 21 ++
 rtl/fb_byte_unpack.sv | 43 ++++
 rtl/fb_readout_dma.sv | 207 ++++++++++++++++++++
 tb/tb_fb_readout_dma.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_readout_pkg.sv
// Shared types and constants for the framebuffer readout DMA.
package fb_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL          = 4'hF;
  localparam logic [31:0] FB_BASE_DEFAULT     = 32'h2000_0000;
  localparam int          TIMEOUT_CYC_DEFAULT = 255;

  // Word-aligned bus address of a byte pointer inside the framebuffer window.
  function automatic logic [31:0] word_addr(input logic [31:0] fb_base,
                                            input logic [31:0] byte_ptr);
    return fb_base | {byte_ptr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fb_byte_unpack.sv
// Holds the last fetched 32-bit word and selects one little-endian byte lane.
module fb_byte_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  output logic [7:0]  byte_o
);

  logic [31:0] word_q;
  logic [31:0] word_d;

  // Replace the buffered word only when a bus read completes.
  always_comb begin
    if (load_i) begin
      word_d = word_i;
    end else begin
      word_d = word_q;
    end
  end

  // Word buffer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= 32'h0000_0000;
    end else begin
      word_q <= word_d;
    end
  end

  // Lane 0 is the lowest byte address (little-endian).
  always_comb begin
    case (lane_i)
      2'd0:    byte_o = word_q[7:0];
      2'd1:    byte_o = word_q[15:8];
      2'd2:    byte_o = word_q[23:16];
      2'd3:    byte_o = word_q[31:24];
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/fb_readout_dma.sv
// Framebuffer readout DMA: Wishbone classic single-read master that streams a
// byte range out of the framebuffer as an 8-bit valid/ready stream.
// Optional feature macro: FB_RD_TIMEOUT_EN (abort a read after TIMEOUT_CYC
// cycles without ack, raising err).
module fb_readout_dma
  import fb_readout_pkg::*;
#(
  parameter logic [31:0] FB_BASE     = FB_BASE_DEFAULT,
  parameter int          LEN_W       = 16,
  parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] base,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bytes_read,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fire_s;
  logic             load_s;
  logic             tmo_hit_s;
  logic [7:0]       lane_byte_s;

  assign fire_s = (state_q == DRAIN) && out_ready;
  assign load_s = (state_q == REQ) && wbm_ack_i;

`ifdef FB_RD_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Count ack-less REQ cycles; held at zero elsewhere so every REQ entry starts fresh.
  always_comb begin
    if ((state_q == REQ) && !wbm_ack_i) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = 16'd0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit_s = (state_q == REQ) && !wbm_ack_i && (tmo_q == 16'(TIMEOUT_CYC - 1));
`else
  // Without the timeout REQ waits for ack indefinitely.
  logic unused_tmo_cfg_s;
  assign unused_tmo_cfg_s = ^TIMEOUT_CYC;
  assign tmo_hit_s        = 1'b0;
`endif

  fb_byte_unpack u_unpack (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_s),
    .word_i (wbm_dat_i),
    .lane_i (ptr_q[1:0]),
    .byte_o (lane_byte_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      bytes_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      bytes_q  <= bytes_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? FINISH : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (wbm_ack_i) begin
          state_d = DRAIN;
        end else if (tmo_hit_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (!fire_s) begin
          state_d = DRAIN;
        end else if (remain_q == LEN_W'(1)) begin
          state_d = FINISH;
        end else if (ptr_q[1:0] == 2'b11) begin
          // Next pointer crosses into a new word.
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer, byte counters and status flags.
  always_comb begin
    ptr_d    = ptr_q;
    remain_d = remain_q;
    bytes_d  = bytes_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d    = base;
          remain_d = len;
          bytes_d  = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end else begin
          ptr_d    = ptr_q;
        end
      end
      REQ: begin
        if (tmo_hit_s) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          err_d  = err_q;
        end
      end
      DRAIN: begin
        if (fire_s) begin
          ptr_d    = ptr_q + LEN_W'(1);
          remain_d = remain_q - LEN_W'(1);
          bytes_d  = bytes_q + LEN_W'(1);
        end else begin
          ptr_d    = ptr_q;
        end
      end
      FINISH:  done_d = 1'b1;
      default: done_d = done_q;
    endcase
  end

  // Outputs decoded from the registered state; address and data read 0 when idle.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = done_q;
    err        = err_q;
    bytes_read = bytes_q;
    wbm_cyc_o  = (state_q == REQ);
    wbm_stb_o  = (state_q == REQ);
    wbm_we_o   = 1'b0;
    wbm_sel_o  = WB_SEL_ALL;
    out_valid  = (state_q == DRAIN);
    out_last   = (state_q == DRAIN) && (remain_q == LEN_W'(1));
    if (state_q == REQ) begin
      wbm_adr_o = word_addr(FB_BASE, 32'(ptr_q));
    end else begin
      wbm_adr_o = 32'h0000_0000;
    end
    if (state_q == DRAIN) begin
      out_data = lane_byte_s;
    end else begin
      out_data = 8'h00;
    end
  end

endmodule

// File: tb/tb_fb_readout_dma.sv
// Self-checking bench for fb_readout_dma: table-driven transfers, randomized
// transfers against a byte-range reference model, reset and timeout sequences.
module tb_fb_readout_dma;

  localparam int          LEN_W = 16;
  localparam int          TMO   = 16;
  localparam logic [31:0] FB    = 32'h2000_0000;
  localparam int          BUDGET = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] base;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [LEN_W-1:0] bytes_read;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_i = 32'h0;
  logic             wbm_ack_i = 1'b0;
  logic             out_valid, out_ready, out_last;
  logic [7:0]       out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fb_readout_dma #(.FB_BASE(FB), .LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .bytes_read(bytes_read), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  // Framebuffer contents: low addresses hold their own index, high bits mix in.
  function automatic logic [7:0] byte_at(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Wishbone slave: acks wait_n cycles after it first registers stb.
  logic         no_ack = 1'b0;
  int           wait_n = 0;
  int           scnt   = 0;
  logic [15:0]  sw;
  logic [31:0]  rd_q[$];

  always @(posedge clk) begin
    #1;
    if (!(wbm_cyc_o && wbm_stb_o) || wbm_ack_i) begin
      wbm_ack_i = 1'b0;
      scnt      = 0;
    end else if (!no_ack && scnt > wait_n) begin
      sw        = {wbm_adr_o[15:2], 2'b00};
      wbm_dat_i = {byte_at(sw + 16'd3), byte_at(sw + 16'd2), byte_at(sw + 16'd1), byte_at(sw)};
      wbm_ack_i = 1'b1;
      rd_q.push_back(wbm_adr_o);
    end else begin
      scnt++;
    end
  end

  // Stream monitor: collects accepted bytes and checks hold-while-stalled.
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic       stab_en    = 1'b1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rst_n && stab_en && prev_stall) begin
      check("stall_hold_valid", out_valid, 1'b1);
      check("stall_hold_data", out_data, prev_data);
    end
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic set_ready(input int mode);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One transfer, then compare everything against the byte-range model.
  task automatic run_xfer(input string tag, input logic [15:0] b, input logic [15:0] l,
                          input int mode, input int wn, input int dup_at,
                          output int first_v, output int done_c, output bit saw_cyc);
    int          c;
    bit          busy1;
    logic [7:0]  exp_b[$];
    logic [31:0] exp_a[$];
    logic [15:0] a;
    int          n;
    wait_n = wn;
    got_q.delete(); got_last_q.delete(); rd_q.delete();
    first_v = -1; saw_cyc = 1'b0; busy1 = 1'b0;
    @(posedge clk); #1;
    base = b; len = l; start = 1'b1;
    set_ready(mode);
    @(posedge clk); #1;
    start = 1'b0; c = 1;
    while (!done && c < BUDGET) begin
      if (c == dup_at) begin
        start = 1'b1; base = 16'h0100; len = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (c == 1) busy1 = busy;
      if (out_valid && first_v < 0) first_v = c;
      if (wbm_cyc_o) saw_cyc = 1'b1;
      set_ready(mode);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    done_c = c;
    check({tag, " done_in_budget"}, 1'(c < BUDGET), 1'b1);
    check({tag, " busy_after_start"}, busy1, 1'b1);
    for (int i = 0; i < int'(l); i++) begin
      a = b + 16'(i);
      exp_b.push_back(byte_at(a));
      if (i == 0 || a[1:0] == 2'b00) exp_a.push_back(FB | {16'h0000, a[15:2], 2'b00});
    end
    check({tag, " byte_count"}, got_q.size(), exp_b.size());
    n = (got_q.size() < exp_b.size()) ? got_q.size() : exp_b.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte[%0d]", tag, i), got_q[i], exp_b[i]);
      check($sformatf("%s last[%0d]", tag, i), got_last_q[i], 1'(i == int'(l) - 1));
    end
    check({tag, " read_count"}, rd_q.size(), exp_a.size());
    n = (rd_q.size() < exp_a.size()) ? rd_q.size() : exp_a.size();
    for (int i = 0; i < n; i++) check($sformatf("%s adr[%0d]", tag, i), rd_q[i], exp_a[i]);
    check({tag, " saw_cyc"}, saw_cyc, 1'(l != 16'd0));
    check({tag, " bytes_read"}, bytes_read, l);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy_end"}, busy, 1'b0);
    check({tag, " err"}, err, 1'b0);
  endtask

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          mode;
    int          wn;
    int          dup_at;
    int          exp_reads;
    logic [31:0] exp_first;
    int          exp_lat;
    int          exp_done_c;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  fv, dc, cyc_hi;
    bit  sc, saw_v;

    vecs[0] = '{16'h0000, 16'd8, 0, 0, -1, 2, 32'h2000_0000, 3, -1};  // aligned
    vecs[1] = '{16'h0003, 16'd5, 0, 0, -1, 2, 32'h2000_0000, 3, -1};  // unaligned
    vecs[2] = '{16'h0000, 16'd8, 1, 0, -1, 2, 32'h2000_0000, -1, -1}; // backpressure
    vecs[3] = '{16'h0000, 16'd0, 0, 0, -1, 0, 32'h0000_0000, -1, 2};  // zero length
    vecs[4] = '{16'h0000, 16'd8, 0, 0, 2, 2, 32'h2000_0000, 3, -1};   // start while busy
    vecs[5] = '{16'hFFFE, 16'd4, 0, 0, -1, 2, 32'h2000_FFFC, 3, -1};  // pointer wrap
    vecs[6] = '{16'h1235, 16'd6, 2, 2, -1, 2, 32'h2000_1234, -1, -1}; // waits + random ready
    vecs[7] = '{16'h0007, 16'd1, 0, 1, -1, 1, 32'h2000_0004, 4, -1};  // one wait state

    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst bytes_read", bytes_read, 16'h0);
    check("rst cyc", wbm_cyc_o, 1'b0);
    check("rst stb", wbm_stb_o, 1'b0);
    check("rst we", wbm_we_o, 1'b0);
    check("rst sel", wbm_sel_o, 4'hF);
    check("rst adr", wbm_adr_o, 32'h0);
    check("rst valid", out_valid, 1'b0);
    check("rst data", out_data, 8'h00);
    check("rst last", out_last, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_xfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode,
               vecs[v].wn, vecs[v].dup_at, fv, dc, sc);
      check($sformatf("vec%0d reads", v), rd_q.size(), vecs[v].exp_reads);
      if (vecs[v].exp_reads > 0 && rd_q.size() > 0)
        check($sformatf("vec%0d first_adr", v), rd_q[0], vecs[v].exp_first);
      if (vecs[v].exp_lat >= 0)
        check($sformatf("vec%0d latency", v), fv, vecs[v].exp_lat);
      if (vecs[v].exp_done_c >= 0)
        check($sformatf("vec%0d done_cycle", v), dc, vecs[v].exp_done_c);
    end

    for (int r = 0; r < 20; r++) begin
      run_xfer($sformatf("rand%0d", r), 16'($urandom), 16'($urandom_range(1, 12)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, fv, dc, sc);
    end

    // Reset mid-transfer, once during a bus request and once while draining.
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1; wait_n = 0;
      @(posedge clk); #1;
      base = 16'h0000; len = 16'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 1) begin
        repeat (2) @(posedge clk);
        #1;
        check("mrst in_drain", out_valid, 1'b1);
      end else begin
        check("mrst in_req", wbm_cyc_o, 1'b1);
      end
      stab_en = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      check($sformatf("mrst%0d cyc", k), wbm_cyc_o, 1'b0);
      check($sformatf("mrst%0d stb", k), wbm_stb_o, 1'b0);
      check($sformatf("mrst%0d valid", k), out_valid, 1'b0);
      check($sformatf("mrst%0d busy", k), busy, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("mrst%0d done", k), done, 1'b0);
      check($sformatf("mrst%0d idle", k), busy, 1'b0);
      stab_en = 1'b1;
    end

`ifdef FB_RD_TIMEOUT_EN
    no_ack = 1'b1; cyc_hi = 0; saw_v = 1'b0;
    @(posedge clk); #1;
    base = 16'h0000; len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 200 && !done; c++) begin
      if (wbm_cyc_o) cyc_hi++;
      if (out_valid) saw_v = 1'b1;
      @(posedge clk); #1;
    end
    check("tmo cyc_cycles", cyc_hi, TMO);
    check("tmo err", err, 1'b1);
    check("tmo done", done, 1'b1);
    check("tmo busy", busy, 1'b0);
    check("tmo cyc_low", wbm_cyc_o, 1'b0);
    check("tmo no_valid", saw_v, 1'b0);
    no_ack = 1'b0;
    run_xfer("after_tmo", 16'h0002, 16'd3, 0, 0, -1, fv, dc, sc);
`else
    check("no_tmo err_tied", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
